// File: rtl/filtr_sched.sv
// Round-robin scheduler that time-shares one notch filter core among NCH sample sources,
// with a WAIT-state watchdog that returns the schedule to IDLE if the core never reports done.
module filtr_sched #(
    parameter int DATA_SIZE = 25,
    parameter int NCH       = 4,
    parameter int CW        = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCH-1:0]              req_valid,
    input  logic [NCH*(DATA_SIZE-1)-1:0] req_data,
    output logic [NCH-1:0]              req_ready,
    output logic [DATA_SIZE-2:0]        flt_data_in,
    output logic                        flt_sample,
    input  logic [DATA_SIZE-2:0]        flt_data_out,
    input  logic                        flt_done,
    output logic                        res_valid,
    output logic [DATA_SIZE-2:0]        res_data,
    output logic [CW-1:0]               res_ch,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int DW = DATA_SIZE - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [DW-1:0] data_in_q, data_in_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [CW-1:0] res_ch_q, res_ch_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] arb_idx;
    logic          accept;

    // First valid channel searching upward from ptr, wrapping modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            arb_idx = CW'((32'(ptr_q) + k) % NCH);
            if (!grant_vld && req_valid[arb_idx]) begin
                grant_vld = 1'b1;
                grant_idx = arb_idx;
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && grant_vld && !reset;
    assign req_ready = accept ? (NCH'(1) << grant_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ch_d       = ch_q;
        data_in_d  = data_in_q;
        res_data_d = res_data_q;
        res_ch_d   = res_ch_q;
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_in_d = req_data[grant_idx*DW +: DW];
                    ch_d      = grant_idx;
                    ptr_d     = CW'((32'(grant_idx) + 32'd1) % NCH);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A done arriving on the last allowed cycle still counts as a result.
                if (flt_done) begin
                    res_data_d = flt_data_out;
                    res_ch_d   = ch_q;
                    state_d    = S_DONE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            ch_q       <= '0;
            data_in_q  <= '0;
            res_data_q <= '0;
            res_ch_q   <= '0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            data_in_q  <= data_in_d;
            res_data_q <= res_data_d;
            res_ch_q   <= res_ch_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
        end
    end

    assign flt_data_in = data_in_q;
    assign flt_sample  = (state_q == S_ISSUE);
    assign res_valid   = (state_q == S_DONE);
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_filtr_sched.sv
// Directed bench for filtr_sched: two instances, watchdog limits 16 (main) and 8 (coincidence case).
module tb_filtr_sched;

    localparam int DS  = 25;
    localparam int DW  = DS - 1;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NCH-1:0]    valid_a = '0, ready_a;
    logic [NCH*DW-1:0] data_a;
    logic [DW-1:0]     din_a, fdo_a = '0, rdata_a;
    logic              sample_a, done_a = 1'b0, rvalid_a, busy_a, tmo_a;
    logic [CW-1:0]     rch_a;

    logic [NCH-1:0]    valid_b = '0, ready_b;
    logic [NCH*DW-1:0] data_b;
    logic [DW-1:0]     din_b, fdo_b = '0, rdata_b;
    logic              sample_b, done_b = 1'b0, rvalid_b, busy_b, tmo_b;
    logic [CW-1:0]     rch_b;

    logic [DW-1:0] ch_data [NCH] = '{24'h0A0A0A, 24'h111111, 24'h123456, 24'h333333};
    assign data_a = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    assign data_b = {24'h777777, 24'h666666, 24'h555555, 24'h0F0F0F};

    filtr_sched #(.DATA_SIZE(DS), .NCH(NCH), .CW(CW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(valid_a), .req_data(data_a), .req_ready(ready_a),
        .flt_data_in(din_a), .flt_sample(sample_a), .flt_data_out(fdo_a), .flt_done(done_a),
        .res_valid(rvalid_a), .res_data(rdata_a), .res_ch(rch_a), .busy(busy_a), .timeout_err(tmo_a)
    );

    filtr_sched #(.DATA_SIZE(DS), .NCH(NCH), .CW(CW), .TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(valid_b), .req_data(data_b), .req_ready(ready_b),
        .flt_data_in(din_b), .flt_sample(sample_b), .flt_data_out(fdo_b), .flt_done(done_b),
        .res_valid(rvalid_b), .res_data(rdata_b), .res_ch(rch_b), .busy(busy_b), .timeout_err(tmo_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for flt_sample on the main instance, then returns a result dly cycles later.
    task automatic serve(input int ch, input logic [DW-1:0] res, input int dly, output int s_cyc);
        int n = 0;
        while (!sample_a && n < 20) begin
            tick();
            n++;
        end
        chk("sample_seen", 32'(sample_a), 1);
        s_cyc = cyc;
        chk("flt_data_in", 32'(din_a), 32'(ch_data[ch]));
        repeat (dly) tick();
        done_a = 1'b1;
        fdo_a  = res;
        tick();
        done_a = 1'b0;
        fdo_a  = '0;
        chk("res_valid", 32'(rvalid_a), 1);
        chk("res_ch", 32'(rch_a), 32'(ch));
        chk("res_data", 32'(rdata_a), 32'(res));
    endtask

    initial begin
        int sc, prev, pulses, rv;

        // Reset values, with requests pending to show req_ready is held low.
        valid_a = 4'hF;
        repeat (2) tick();
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_sample", 32'(sample_a), 0);
        chk("rst_din", 32'(din_a), 0);
        chk("rst_rvalid", 32'(rvalid_a), 0);
        chk("rst_rdata", 32'(rdata_a), 0);
        chk("rst_rch", 32'(rch_a), 0);
        chk("rst_tmo", 32'(tmo_a), 0);
        valid_a = '0;
        reset = 1'b0;
        tick();

        // Single request on ch2.
        valid_a = 4'b0100;
        #1;
        chk("t1_ready", 32'(ready_a), 32'b0100);
        tick();
        valid_a = '0;
        chk("t1_sample", 32'(sample_a), 1);
        serve(2, 24'h00ABCD, 5, sc);
        tick();
        chk("t1_busy_after", 32'(busy_a), 0);
        chk("t1_rvalid_once", 32'(rvalid_a), 0);
        chk("t1_rdata_hold", 32'(rdata_a), 32'h00ABCD);

        // Fairness after reset: ptr was 3, must restart at 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        valid_a = 4'hF;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            serve(k % NCH, 24'hA00000 + 24'(k), 5, sc);
            if (k > 0) chk("t2_period", 32'(sc - prev), 8);
            prev = sc;
        end
        valid_a = '0;
        tick();

        // Watchdog: ch2 (ptr=2) never completes, ch3 waits behind it.
        valid_a = 4'b0100;
        tick();
        valid_a = 4'b1000;
        chk("t3_sample", 32'(sample_a), 1);
        pulses = 0;
        rv = 0;
        repeat (16) begin
            tick();
            pulses += int'(tmo_a);
            rv += int'(rvalid_a);
        end
        chk("t3_early_tmo", 32'(pulses), 0);
        tick();
        chk("t3_tmo", 32'(tmo_a), 1);
        chk("t3_no_rvalid", 32'(rv + int'(rvalid_a)), 0);
        chk("t3_next_grant", 32'(ready_a), 32'b1000);
        chk("t3_rdata_hold", 32'(rdata_a), 32'hA00005);
        tick();
        valid_a = '0;
        chk("t3_tmo_one_cycle", 32'(tmo_a), 0);
        serve(3, 24'h3C3C3C, 4, sc);
        tick();

        // Spurious done in IDLE and in ISSUE.
        done_a = 1'b1;
        fdo_a  = 24'hBAD000;
        tick();
        done_a = 1'b0;
        chk("t4_idle_busy", 32'(busy_a), 0);
        chk("t4_idle_rvalid", 32'(rvalid_a), 0);
        valid_a = 4'b0001;
        tick();
        valid_a = '0;
        done_a  = 1'b1;
        chk("t4_issue", 32'(sample_a), 1);
        tick();
        done_a = 1'b0;
        chk("t4_wait_busy", 32'(busy_a), 1);
        chk("t4_wait_rvalid", 32'(rvalid_a), 0);
        repeat (2) tick();
        done_a = 1'b1;
        fdo_a  = 24'h5A5A5A;
        tick();
        done_a = 1'b0;
        chk("t4_rvalid", 32'(rvalid_a), 1);
        chk("t4_rdata", 32'(rdata_a), 32'h5A5A5A);
        chk("t4_rch", 32'(rch_a), 0);
        tick();
        chk("t4_single", 32'(rvalid_a), 0);

        // Reset while waiting on ch3 (ptr=1 so search reaches 3).
        valid_a = 4'b1000;
        tick();
        valid_a = '0;
        repeat (2) tick();
        chk("t5_busy_pre", 32'(busy_a), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(busy_a), 0);
        chk("t5_din", 32'(din_a), 0);
        chk("t5_rdata", 32'(rdata_a), 0);
        chk("t5_rch", 32'(rch_a), 0);
        chk("t5_ready", 32'(ready_a), 0);
        chk("t5_sample", 32'(sample_a) | 32'(rvalid_a) | 32'(tmo_a), 0);
        done_a = 1'b1;
        rv = 0;
        repeat (6) begin
            tick();
            done_a = 1'b0;
            rv += int'(rvalid_a);
        end
        chk("t5_no_result", 32'(rv), 0);
        valid_a = 4'b1010;
        #1;
        chk("t5_grant_ch1", 32'(ready_a), 32'b0010);
        tick();
        valid_a = '0;
        serve(1, 24'h010101, 3, sc);

        // Done coincident with the last allowed WAIT cycle, TIMEOUT=8.
        valid_b = 4'b0001;
        tick();
        valid_b = '0;
        chk("t6_sample", 32'(sample_b), 1);
        chk("t6_din", 32'(din_b), 32'h0F0F0F);
        repeat (8) tick();
        done_b = 1'b1;
        fdo_b  = 24'hC0FFEE;
        tick();
        done_b = 1'b0;
        chk("t6_rvalid", 32'(rvalid_b), 1);
        chk("t6_rdata", 32'(rdata_b), 32'hC0FFEE);
        chk("t6_tmo", 32'(tmo_b), 0);
        tick();
        chk("t6_tmo_after", 32'(tmo_b), 0);
        chk("t6_busy", 32'(busy_b), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
